// File: rtl/step_mon_pkg.sv
// Shared types and helpers for step_response_monitor and its band comparator.
package step_mon_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, TRACK, DONE} state_t;

  // Extra bits that keep in_val - target from wrapping.
  localparam int ERR_EXT = 1;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
    return (cnt >= max_val) ? max_val : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/band_compare.sv
// Registered |in_val - target| <= tol check on signed fixed-point values.
// The result is independent of the shared exponent, so other checkers can reuse it.
module band_compare
  import step_mon_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_val,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] tol,
  output logic             in_band
);

  localparam int EW = WIDTH + ERR_EXT;

  logic signed [EW-1:0] err;
  logic signed [EW-1:0] abs_err;
  logic signed [EW-1:0] tol_ext;
  logic                 in_band_d;

  // A negative tolerance can never be met because abs_err is never negative.
  always_comb begin
    err       = $signed({{ERR_EXT{in_val[WIDTH-1]}}, in_val})
              - $signed({{ERR_EXT{target[WIDTH-1]}}, target});
    abs_err   = err[EW-1] ? -err : err;
    tol_ext   = $signed({{ERR_EXT{tol[WIDTH-1]}}, tol});
    in_band_d = (abs_err <= tol_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) in_band <= 1'b0;
    else     in_band <= in_band_d;
  end

endmodule

// File: rtl/step_response_monitor.sv
// Settling-time monitor for an emulated analog output after a stimulus step.
// Optional feature macro: STEP_MON_PEAK_EN (tracks the signed peak of in_val).
module step_response_monitor
  import step_mon_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int EXPONENT    = -12,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_val,
  input  logic [WIDTH-1:0]     target,
  input  logic [WIDTH-1:0]     tol,
  output logic                 busy,
  output logic                 done,
  output logic                 settled,
  output logic [CNT_WIDTH-1:0] settle_time,
  output logic [WIDTH-1:0]     peak_val
);

  localparam int                   RUN_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [RUN_W-1:0]     HOLD_C    = RUN_W'(HOLD_CYCLES);

  // Ports carry fractional fixed-point values; the counter must be able to report TIMEOUT.
  if (HOLD_CYCLES < 1 || TIMEOUT < 1 || TIMEOUT >= (1 << CNT_WIDTH) || EXPONENT > 0) begin : g_bad_params
    $error("step_response_monitor: invalid parameter set");
  end

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     target_q;
  logic [WIDTH-1:0]     tol_q;
  logic [CNT_WIDTH-1:0] k;
  logic [CNT_WIDTH-1:0] k_inc;
  logic [CNT_WIDTH-1:0] k0;
  logic [CNT_WIDTH-1:0] k0_cur;
  logic [RUN_W-1:0]     run;
  logic [RUN_W-1:0]     run_inc;
  logic                 in_band;
  logic                 success;
  logic                 timeout_hit;

  band_compare #(.WIDTH(WIDTH)) u_band (
    .clk     (emu_clk),
    .rst     (emu_rst),
    .in_val  (in_val),
    .target  (target_q),
    .tol     (tol_q),
    .in_band (in_band)
  );

  // k0_cur covers HOLD_CYCLES=1, where success arrives before k0 is stored.
  always_comb begin
    k_inc       = CNT_WIDTH'(sat_inc(32'(k), 32'(TIMEOUT)));
    run_inc     = RUN_W'(sat_inc(32'(run), 32'(HOLD_CYCLES)));
    k0_cur      = (run == '0) ? k : k0;
    success     = (state == TRACK) && in_band && (run_inc == HOLD_C);
    timeout_hit = (state == TRACK) && !success && (k_inc == TIMEOUT_C);
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ARMED;
    end else begin
      case (state)
        ARMED:   state_next = TRACK;
        TRACK:   if (success || timeout_hit) state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    busy = (state == ARMED) || (state == TRACK);
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      target_q    <= '0;
      tol_q       <= '0;
      k           <= '0;
      k0          <= '0;
      run         <= '0;
      done        <= 1'b0;
      settled     <= 1'b0;
      settle_time <= '0;
    end else if (start) begin
      target_q <= target;
      tol_q    <= tol;
      k        <= '0;
      k0       <= '0;
      run      <= '0;
      done     <= 1'b0;
      settled  <= 1'b0;
    end else if (state == TRACK) begin
      k <= k_inc;
      if (in_band) begin
        run <= run_inc;
        k0  <= k0_cur;
      end else begin
        run <= '0;
      end
      if (success) begin
        done        <= 1'b1;
        settled     <= 1'b1;
        settle_time <= k0_cur;
      end else if (timeout_hit) begin
        done        <= 1'b1;
        settled     <= 1'b0;
        settle_time <= TIMEOUT_C;
      end
    end
  end

`ifdef STEP_MON_PEAK_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] peak_q;

  // Every in_val seen while busy is a sample of the current measurement.
  always_ff @(posedge emu_clk) begin
    if (emu_rst)                                           peak_q <= '0;
    else if (start)                                        peak_q <= MOST_NEG;
    else if (busy && ($signed(in_val) > $signed(peak_q))) peak_q <= in_val;
  end

  assign peak_val = peak_q;
`else
  assign peak_val = '0;
`endif

endmodule

// File: tb/tb_step_response_monitor.sv
// Self-checking bench for step_response_monitor: directed spec cases plus randomized
// settling waveforms, all checked every cycle against a sample-level reference model.
`timescale 1ns/1ps
module tb_step_response_monitor;

  localparam int WIDTH     = 16;
  localparam int HOLD      = 4;
  localparam int TIMEOUT   = 1024;
  localparam int CNT_WIDTH = 16;
  localparam int NSTIM     = 1100;

  logic                     emu_clk = 1'b0;
  logic                     emu_rst;
  logic                     start;
  logic signed [WIDTH-1:0]  in_val;
  logic signed [WIDTH-1:0]  target;
  logic signed [WIDTH-1:0]  tol;
  logic                     busy;
  logic                     done;
  logic                     settled;
  logic [CNT_WIDTH-1:0]     settle_time;
  logic signed [WIDTH-1:0]  peak_val;

  int cyc = 0;
  int stim[NSTIM];
  int pk[NSTIM];
  int start_cyc;
  int exp_done_cyc;
  int exp_st;
  bit exp_succ;
  bit meas_mode;
  bit chk_en;
  int skip_cyc = -1;
  int n_checks;
  int n_fails;

  step_response_monitor #(
    .WIDTH       (WIDTH),
    .EXPONENT    (-12),
    .HOLD_CYCLES (HOLD),
    .TIMEOUT     (TIMEOUT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .emu_clk     (emu_clk),
    .emu_rst     (emu_rst),
    .start       (start),
    .in_val      (in_val),
    .target      (target),
    .tol         (tol),
    .busy        (busy),
    .done        (done),
    .settled     (settled),
    .settle_time (settle_time),
    .peak_val    (peak_val)
  );

  always #5 emu_clk = ~emu_clk;

  always @(posedge emu_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  // Sample k settles the measurement once HOLD consecutive in-band samples end at k.
  function automatic void build_model(input int tgt, input int tl);
    int run_len;
    int mx;
    run_len      = 0;
    exp_succ     = 1'b0;
    exp_st       = TIMEOUT;
    exp_done_cyc = start_cyc + TIMEOUT + 2;
    for (int k = 0; k < TIMEOUT; k++) begin
      int e;
      e = stim[k] - tgt;
      if (e < 0) e = -e;
      if (e <= tl) run_len++;
      else         run_len = 0;
      if (run_len == HOLD) begin
        exp_succ     = 1'b1;
        exp_st       = k - HOLD + 1;
        exp_done_cyc = start_cyc + 3 + k;
        break;
      end
    end
    mx = -32768;
    for (int k = 0; k < NSTIM; k++) begin
      if (stim[k] > mx) mx = stim[k];
      pk[k] = mx;
    end
  endfunction

  task automatic applyStimulus();
    int idx;
    @(posedge emu_clk);
    #1;
    start   = 1'b0;
    emu_rst = 1'b0;
    target  = WIDTH'($urandom);
    tol     = WIDTH'($urandom);
    if (meas_mode) begin
      idx = cyc - start_cyc - 1;
      if (idx < 0) idx = 0;
      if (idx >= NSTIM) idx = NSTIM - 1;
      in_val = WIDTH'(stim[idx]);
    end else begin
      in_val = WIDTH'($urandom);
    end
  endtask

  task automatic begin_meas(input int tgt, input int tl);
    start     = 1'b1;
    target    = WIDTH'(tgt);
    tol       = WIDTH'(tl);
    start_cyc = cyc;
    skip_cyc  = cyc;
    meas_mode = 1'b1;
    build_model(tgt, tl);
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      applyStimulus();
      @(negedge emu_clk);
      if (done) break;
    end
    checkOutput("wait_done", int'(done), 1);
  endtask

  task automatic run_meas(input int tgt, input int tl, output int lat);
    applyStimulus();
    begin_meas(tgt, tl);
    wait_done(TIMEOUT + 20);
    lat = cyc - start_cyc;
    checkOutput("done_cycle", lat, exp_done_cyc - start_cyc);
    repeat (3) applyStimulus();
    @(negedge emu_clk);
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < NSTIM; k++) stim[k] = v;
  endtask

  task automatic fill_random(output int tgt, output int tl);
    int e;
    int v;
    tgt = int'($urandom_range(0, 16000)) - 8000;
    tl  = int'($urandom_range(0, 120));
    if ($urandom_range(0, 7) == 0) tl = -int'($urandom_range(1, 50));
    e = int'($urandom_range(0, 16000)) - 8000;
    for (int k = 0; k < NSTIM; k++) begin
      v = tgt + e + int'($urandom_range(0, 60)) - 30;
      if ($urandom_range(0, 19) == 0) v += 300;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      stim[k] = v;
      e = (e * 3) / 4;
    end
  endtask

  // Per-cycle comparison of every output against the reference model.
  always @(negedge emu_clk) begin
    bit ed;
    int j;
    if (chk_en && cyc != skip_cyc) begin
      if (!meas_mode) begin
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_done", int'(done), 0);
        checkOutput("idle_settled", int'(settled), 0);
        checkOutput("idle_settle_time", int'(settle_time), 0);
        checkOutput("idle_peak", int'(peak_val), 0);
      end else begin
        ed = (cyc >= exp_done_cyc);
        checkOutput("busy", int'(busy), int'(!ed));
        checkOutput("done", int'(done), int'(ed));
        checkOutput("settled", int'(settled), int'(ed && exp_succ));
        if (ed) checkOutput("settle_time", int'(settle_time), exp_st);
`ifdef STEP_MON_PEAK_EN
        j = ((cyc < exp_done_cyc) ? cyc : exp_done_cyc) - start_cyc - 2;
        checkOutput("peak", int'(peak_val), (j < 0) ? -32768 : pk[j]);
`else
        j = 0;
        checkOutput("peak", int'(peak_val), j);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int tgt;
    int tl;
    emu_rst   = 1'b1;
    start     = 1'b0;
    in_val    = '0;
    target    = '0;
    tol       = '0;
    meas_mode = 1'b0;
    chk_en    = 1'b0;
    n_checks  = 0;
    n_fails   = 0;
    repeat (2) @(posedge emu_clk);
    #1;
    chk_en = 1'b1;
    @(negedge emu_clk);
    checkOutput("reset_done", int'(done), 0);

    $display("[TB] case 1: constant in-band input");
    fill_const(4096);
    run_meas(4096, 41, lat);
    checkOutput("t1_latency", lat, 6);
    checkOutput("t1_settled", int'(settled), 1);
    checkOutput("t1_settle_time", int'(settle_time), 0);
    checkOutput("t1_busy", int'(busy), 0);

    $display("[TB] case 2: ramp then hold");
    for (int k = 0; k < NSTIM; k++) stim[k] = (k <= 8) ? k * 512 : 4096;
    run_meas(4096, 41, lat);
    checkOutput("t2_settled", int'(settled), 1);
    checkOutput("t2_settle_time", int'(settle_time), 8);

    $display("[TB] case 3: toggling excursions");
    for (int k = 0; k < NSTIM; k++) stim[k] = (k < 20 && (k % 2) == 1) ? 4300 : 4096;
    run_meas(4096, 41, lat);
    checkOutput("t3_settle_time", int'(settle_time), 20);

    $display("[TB] case 4: tolerance boundary");
    fill_const(4137);
    run_meas(4096, 41, lat);
    checkOutput("t4_boundary_settled", int'(settled), 1);
    fill_const(4138);
    run_meas(4096, 41, lat);
    checkOutput("t4_outside_settled", int'(settled), 0);
    checkOutput("t4_outside_settle_time", int'(settle_time), 1024);
    checkOutput("t4_timeout_latency", lat, 1026);

    $display("[TB] case 5: restart and reset");
    fill_const(3000);
    applyStimulus();
    begin_meas(4096, 41);
    repeat (3) applyStimulus();
    fill_const(0);
    begin_meas(0, 41);
    wait_done(40);
    checkOutput("t5_restart_latency", cyc - start_cyc, 6);
    checkOutput("t5_restart_settle_time", int'(settle_time), 0);
    fill_const(4096);
    applyStimulus();
    begin_meas(4096, 41);
    repeat (4) applyStimulus();
    emu_rst   = 1'b1;
    start     = 1'b1;
    meas_mode = 1'b0;
    skip_cyc  = cyc;
    repeat (4) applyStimulus();
    @(negedge emu_clk);
    checkOutput("t5_reset_busy", int'(busy), 0);
    checkOutput("t5_reset_done", int'(done), 0);

    $display("[TB] case 6: peak tracking");
    for (int k = 0; k < NSTIM; k++) stim[k] = 4096;
    stim[0] = 0;
    stim[1] = 2048;
    stim[2] = 5000;
    stim[3] = 4500;
    run_meas(4096, 41, lat);
    checkOutput("t6_settle_time", int'(settle_time), 4);
`ifdef STEP_MON_PEAK_EN
    checkOutput("t6_peak", int'(peak_val), 5000);
`else
    checkOutput("t6_peak", int'(peak_val), 0);
`endif

    $display("[TB] full-scale and negative tolerance");
    fill_const(32767);
    run_meas(-32768, 32767, lat);
    checkOutput("fs_wide_err_settled", int'(settled), 0);
    fill_const(-1);
    run_meas(-32768, 32767, lat);
    checkOutput("fs_edge_settle_time", int'(settle_time), 0);
    fill_const(4096);
    run_meas(4096, -1, lat);
    checkOutput("neg_tol_settle_time", int'(settle_time), 1024);

    $display("[TB] randomized settling waveforms");
    for (int r = 0; r < 10; r++) begin
      fill_random(tgt, tl);
      run_meas(tgt, tl, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
